lu_seq: RTL

//   Multi-cycle logic unit: successor to the 1-bit AND/OR unit with a

---
 rtl/lu_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/lu_seq.sv
// Multi-cycle bitwise logic unit: SLICE bits per RUN cycle, LS slice first, with an accumulator feedback path.
// Latency NSLICE cycles from accept to out_valid; out_ready low holds DONE and blocks new accepts.
module lu_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    base;
  logic [SLICE-1:0] sl_res;

  function automatic logic [SLICE-1:0] slice_op(input logic [2:0] f,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y);
    case (f)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x ^ y;
      3'b011:  return ~(x & y);
      3'b100:  return ~(x | y);
      3'b101:  return ~(x ^ y);
      3'b110:  return ~x;
      default: return x;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign base   = IW'(int'(cnt_q) * SLICE);
  assign sl_res = slice_op(op_q, opa_q[base +: SLICE], b_q[base +: SLICE]);

  always_comb begin
    opa_d    = opa_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    acc_d    = acc_q;
    if (state_q == IDLE && in_valid) begin
      opa_d = use_acc ? acc_q : a;
      b_d   = b;
      op_d  = op;
      cnt_d = '0;
    end
    if (state_q == RUN) begin
      result_d[base +: SLICE] = sl_res;
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    // Clear takes priority over the DONE handoff write-back.
    if (clr_acc)                             acc_d = '0;
    else if (state_q == DONE && out_ready)   acc_d = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
    end else begin
      opa_q    <= opa_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      acc_q    <= acc_d;
    end
  end

  assign result = result_q;
  assign zero   = ~|result_q;
  assign parity = ^result_q;

endmodule
